// File: rtl/cpu_pkg.sv
// Shared encodings for the moxie decode stage: instruction forms, FORM1 opcodes,
// branch condition codes and the opcode ranges that decode as illegal.
package cpu_pkg;

    typedef enum logic [1:0] {
        Form1   = 2'b00,
        FormIll = 2'b01,
        Form2   = 2'b10,
        Form3   = 2'b11
    } form_e;

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpLdiL  = 8'h01;
    localparam logic [7:0] OpMov   = 8'h02;
    localparam logic [7:0] OpJsra  = 8'h03;
    localparam logic [7:0] OpRet   = 8'h04;
    localparam logic [7:0] OpLdaL  = 8'h08;
    localparam logic [7:0] OpStaL  = 8'h09;
    localparam logic [7:0] OpLdoL  = 8'h0C;
    localparam logic [7:0] OpStoL  = 8'h0D;
    localparam logic [7:0] OpJmpa  = 8'h1A;
    localparam logic [7:0] OpLdiB  = 8'h1B;
    localparam logic [7:0] OpLdaB  = 8'h1D;
    localparam logic [7:0] OpStaB  = 8'h1F;
    localparam logic [7:0] OpLdiS  = 8'h20;
    localparam logic [7:0] OpLdaS  = 8'h22;
    localparam logic [7:0] OpStaS  = 8'h24;
    localparam logic [7:0] OpSwi   = 8'h30;
    localparam logic [7:0] OpLdoB  = 8'h36;
    localparam logic [7:0] OpStoB  = 8'h37;
    localparam logic [7:0] OpLdoS  = 8'h38;
    localparam logic [7:0] OpStoS  = 8'h39;

    localparam logic [3:0] CondEq  = 4'h0;
    localparam logic [3:0] CondNe  = 4'h1;
    localparam logic [3:0] CondLt  = 4'h2;
    localparam logic [3:0] CondGt  = 4'h3;
    localparam logic [3:0] CondLtu = 4'h4;
    localparam logic [3:0] CondGtu = 4'h5;
    localparam logic [3:0] CondGe  = 4'h6;
    localparam logic [3:0] CondLe  = 4'h7;
    localparam logic [3:0] CondGeu = 4'h8;
    localparam logic [3:0] CondLeu = 4'h9;

    localparam logic [7:0] Ill0Lo    = 8'h0F;
    localparam logic [7:0] Ill0Hi    = 8'h18;
    localparam logic [7:0] Ill1Lo    = 8'h3A;
    localparam logic [7:0] Ill1Hi    = 8'h3F;
    localparam logic [3:0] CondIllLo = 4'hA;

    function automatic logic f1_has_operand(input logic [7:0] op);
        case (op)
            OpLdiL, OpJsra, OpLdaL, OpStaL, OpLdoL, OpStoL, OpJmpa, OpLdiB, OpLdaB, OpStaB,
            OpLdiS, OpLdaS, OpStaS, OpSwi, OpLdoB, OpStoB, OpLdoS, OpStoS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f1_illegal(input logic [7:0] op);
        return ((op >= Ill0Lo) && (op <= Ill0Hi)) || ((op >= Ill1Lo) && (op <= Ill1Hi));
    endfunction

endpackage

// File: rtl/cpu_decode_fields.sv
// Combinational crack of one moxie instruction word (plus trailing operand) into
// form, op, register and immediate fields with an illegal-opcode flag.
module cpu_decode_fields
    import cpu_pkg::*;
#(
    parameter int unsigned OPERAND_W = 32,
    parameter int unsigned REG_W     = 4
) (
    input  logic [15:0]          opcode_i,
    input  logic [31:0]          operand_i,
    output logic [1:0]           form_o,
    output logic [7:0]           op_o,
    output logic [REG_W-1:0]     ra_o,
    output logic [REG_W-1:0]     rb_o,
    output logic [OPERAND_W-1:0] imm_o,
    output logic                 has_operand_o,
    output logic                 illegal_o
);

    form_e form;

    assign form   = form_e'(opcode_i[15:14]);
    assign form_o = form;

    always_comb begin
        op_o          = '0;
        ra_o          = '0;
        rb_o          = '0;
        imm_o         = '0;
        has_operand_o = 1'b0;
        illegal_o     = 1'b0;
        unique case (form)
            Form1: begin
                op_o          = opcode_i[15:8];
                ra_o          = REG_W'(opcode_i[7:4]);
                rb_o          = REG_W'(opcode_i[3:0]);
                has_operand_o = f1_has_operand(opcode_i[15:8]);
                illegal_o     = f1_illegal(opcode_i[15:8]);
                if (has_operand_o) begin
                    imm_o = OPERAND_W'(operand_i);
                end
            end
            FormIll: illegal_o = 1'b1;
            Form2: begin
                op_o  = {6'b0, opcode_i[13:12]};
                ra_o  = REG_W'(opcode_i[11:8]);
                imm_o = OPERAND_W'(opcode_i[7:0]);
            end
            Form3: begin
                op_o      = {4'b0, opcode_i[13:10]};
                illegal_o = (opcode_i[13:10] >= CondIllLo);
                // Branch offset is a halfword count; sign-extend the doubled value.
                imm_o     = {{(OPERAND_W-11){opcode_i[9]}}, opcode_i[9:0], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_decode_pipe.sv
// Registered moxie decode stage: valid/ready handshake with optional 2-entry skid,
// flush, and a saturating count of delivered illegal instructions.
module cpu_decode_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned OPERAND_W = 32,
    parameter int unsigned REG_W     = 4,
    parameter int unsigned SKID      = 1,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TRACE     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [15:0]          opcode_i,
    input  logic [31:0]          operand_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [1:0]           form_o,
    output logic [7:0]           op_o,
    output logic [REG_W-1:0]     ra_o,
    output logic [REG_W-1:0]     rb_o,
    output logic [OPERAND_W-1:0] imm_o,
    output logic                 has_operand_o,
    output logic                 illegal_o,
    output logic [CNT_W-1:0]     illegal_cnt_o
);

    localparam int unsigned BundleW = 2 + 8 + 2 * REG_W + OPERAND_W + 2;

    logic [1:0]           dec_form;
    logic [7:0]           dec_op;
    logic [REG_W-1:0]     dec_ra;
    logic [REG_W-1:0]     dec_rb;
    logic [OPERAND_W-1:0] dec_imm;
    logic                 dec_has_operand;
    logic                 dec_illegal;
    logic [BundleW-1:0]   dec_bundle;

    logic [BundleW-1:0]   out_q, out_d;
    logic [BundleW-1:0]   skid_q, skid_d;
    logic                 valid_q, valid_d;
    logic                 skid_full_q, skid_full_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_fire, out_fire;
    logic                 unused_trace;

    cpu_decode_fields #(
        .OPERAND_W(OPERAND_W),
        .REG_W    (REG_W)
    ) u_fields (
        .opcode_i     (opcode_i),
        .operand_i    (operand_i),
        .form_o       (dec_form),
        .op_o         (dec_op),
        .ra_o         (dec_ra),
        .rb_o         (dec_rb),
        .imm_o        (dec_imm),
        .has_operand_o(dec_has_operand),
        .illegal_o    (dec_illegal)
    );

    assign dec_bundle = {dec_form, dec_op, dec_ra, dec_rb, dec_imm, dec_has_operand, dec_illegal};

    assign ready_o  = (SKID != 0) ? !skid_full_q : (!valid_q || ready_i);
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_q && ready_i;

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        valid_d     = valid_q;
        skid_full_d = skid_full_q;
        cnt_d       = cnt_q;
        if (out_fire && out_q[0] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush_i) begin
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
        end else if (!valid_q || ready_i) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_full_q) begin
                out_d       = skid_q;
                valid_d     = 1'b1;
                skid_full_d = 1'b0;
            end else if (in_fire) begin
                out_d   = dec_bundle;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (in_fire && (SKID != 0)) begin
            skid_d      = dec_bundle;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            out_q       <= '0;
            skid_q      <= '0;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            valid_q     <= valid_d;
            skid_full_q <= skid_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid_o       = valid_q;
    assign {form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o} = out_q;
    assign illegal_cnt_o = cnt_q;

    // Mnemonic trace is a simulation-only concern and has no hardware.
    assign unused_trace = (TRACE != 0);

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// Scoreboard bench for cpu_decode_pipe: reference decode from the instruction-set
// rules, pushed on in-transfer and popped/compared on out-transfer.
module tb_cpu_decode_pipe;

    typedef struct packed {
        logic [1:0]  form;
        logic [7:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
        logic        has;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] opcode_i = '0;
    logic [31:0] operand_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o, valid_o, has_operand_o, illegal_o;
    logic [1:0]  form_o;
    logic [7:0]  op_o;
    logic [3:0]  ra_o, rb_o;
    logic [31:0] imm_o;
    logic [15:0] illegal_cnt_o;

    logic        s_ready, s_valid, s_has, s_ill;
    logic [1:0]  s_form;
    logic [7:0]  s_op;
    logic [3:0]  s_ra, s_rb;
    logic [31:0] s_imm;
    logic [1:0]  s_cnt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_cnt = 0;

    always #5 clk = ~clk;

    cpu_decode_pipe #(.OPERAND_W(32), .REG_W(4), .SKID(1), .CNT_W(16), .TRACE(0)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .form_o(form_o), .op_o(op_o), .ra_o(ra_o), .rb_o(rb_o),
        .imm_o(imm_o), .has_operand_o(has_operand_o), .illegal_o(illegal_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    cpu_decode_pipe #(.OPERAND_W(32), .REG_W(4), .SKID(1), .CNT_W(2), .TRACE(0)) u_small (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
        .valid_i(valid_i), .ready_o(s_ready), .flush_i(flush_i), .valid_o(s_valid),
        .ready_i(ready_i), .form_o(s_form), .op_o(s_op), .ra_o(s_ra), .rb_o(s_rb),
        .imm_o(s_imm), .has_operand_o(s_has), .illegal_o(s_ill), .illegal_cnt_o(s_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [15:0] opc, input logic [31:0] opd);
        exp_t e;
        int   w, hi, cond, off;
        e    = '0;
        w    = int'(opc);
        hi   = w / 256;
        if (w < 'h4000) begin
            e.form = 2'b00;
            e.op   = 8'(hi);
            e.ra   = 4'((w / 16) % 16);
            e.rb   = 4'(w % 16);
            e.has  = hi inside {1, 3, 8, 9, 12, 13, 26, 27, 29, 31, 32, 34, 36, 48, [54:57]};
            e.ill  = (hi >= 15 && hi <= 24) || (hi >= 58);
            if (e.has) e.imm = opd;
        end else if (w < 'h8000) begin
            e.form = 2'b01;
            e.ill  = 1'b1;
        end else if (w < 'hC000) begin
            e.form = 2'b10;
            e.op   = 8'((w / 4096) % 4);
            e.ra   = 4'((w / 256) % 16);
            e.imm  = 32'(w % 256);
        end else begin
            cond   = (w / 1024) % 16;
            off    = w % 1024;
            if (off >= 512) off = off - 1024;
            e.form = 2'b11;
            e.op   = 8'(cond);
            e.ill  = (cond >= 10);
            e.imm  = 32'(off * 2);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_i || flush_i) exp_q.delete();
        else if (valid_i && ready_o) exp_q.push_back(ref_decode(opcode_i, operand_i));
    end

    exp_t prev_out;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t act, e;
        act = {form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o};
        if (!rst_i) begin
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            check("cnt", 64'(illegal_cnt_o), 64'(model_cnt));
            check("cnt_sat2", 64'(s_cnt), 64'((model_cnt > 3) ? 3 : model_cnt));
            if (prev_stall) check("hold", 64'(act), 64'(prev_out));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("bundle", 64'(act), 64'(e));
                    if (e.ill && model_cnt < 65535) model_cnt++;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_out   = act;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_word();
        opcode_i  = 16'($urandom);
        operand_i = $urandom;
    endtask

    task automatic send(input logic [15:0] opc, input logic [31:0] opd);
        logic took;
        opcode_i  = opc;
        operand_i = opd;
        valid_i   = 1'b1;
        took      = 1'b0;
        for (int k = 0; k < 50 && !took; k++) begin
            took = ready_o;
            tick();
        end
        valid_i = 1'b0;
        if (!took) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, 64'(valid_o), 64'(0));
        check({name, "_ready"}, 64'(ready_o), 64'(1));
        check({name, "_cnt"}, 64'(illegal_cnt_o), 64'(0));
        check({name, "_data"}, 64'({form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o}),
              64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        logic fire;
        exp_t act;

        tick();
        tick();
        check_reset_state("reset");
        rst_i   = 1'b1;
        ready_i = 1'b1;
        tick();

        send(16'h0123, 32'hDEADBEEF);
        act = {form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o};
        check("lat_valid", 64'(valid_o), 64'(1));
        check("insn_0123", 64'(act), 64'({2'b00, 8'h01, 4'h2, 4'h3, 32'hDEADBEEF, 1'b1, 1'b0}));
        send(16'h8A05, 32'h12345678);
        act = {form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o};
        check("insn_8a05", 64'(act), 64'({2'b10, 8'h00, 4'hA, 4'h0, 32'h5, 1'b0, 1'b0}));
        send(16'hC3FF, 32'h0);
        act = {form_o, op_o, ra_o, rb_o, imm_o, has_operand_o, illegal_o};
        check("insn_c3ff", 64'(act), 64'({2'b11, 8'h00, 4'h0, 4'h0, 32'hFFFFFFFE, 1'b0, 1'b0}));
        tick();

        // Stall under continuous traffic, then flush with skid full and valid_i high.
        ready_i = 1'b0;
        valid_i = 1'b1;
        new_word();
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            fire = ready_o;
            tick();
            if (fire) begin
                acc++;
                new_word();
            end
        end
        check("stall_accepts", 64'(acc), 64'(2));
        check("stall_ready", 64'(ready_o), 64'(0));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_valid", 64'(valid_o), 64'(0));
        check("flush_ready", 64'(ready_o), 64'(1));
        ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            new_word();
            tick();
        end
        valid_i = 1'b0;
        tick();
        tick();

        // Illegal counting and saturation of the narrow counter.
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        send(16'h1000, 32'h0);
        send(16'h4000, 32'h0);
        send(16'hE800, 32'h0);
        tick();
        tick();
        check("ill_cnt3", 64'(illegal_cnt_o), 64'(3));
        check("ill_small3", 64'(s_cnt), 64'(3));
        send(16'h3A00, 32'h0);
        send(16'h7FFF, 32'h0);
        tick();
        tick();
        check("ill_cnt5", 64'(illegal_cnt_o), 64'(5));
        check("ill_small_sat", 64'(s_cnt), 64'(3));

        // Random traffic with back-pressure, flushes and one mid-stream reset.
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom % 4) != 0;
            ready_i = ($urandom % 3) != 0;
            flush_i = ($urandom % 25) == 0;
            new_word();
            if (c == 200) begin
                rst_i = 1'b0;
                tick();
                check_reset_state("mid_reset");
                rst_i = 1'b1;
            end else begin
                tick();
            end
        end

        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_valid", 64'(valid_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
